// File: rtl/action_selector.sv
// Epsilon-greedy action selector: explores with an LFSR-drawn action or exploits by fetching
// four Q-values for the latched state and returning the signed argmax.
module action_selector #(
  parameter int unsigned QW        = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    st,
  input  logic [7:0]    epsilon,
  output logic          q_rd_en,
  output logic [3:0]    q_state,
  output logic [1:0]    q_act,
  input  logic          q_rd_valid,
  input  logic [QW-1:0] q_rd_data,
  output logic [1:0]    act,
  output logic          act_valid,
  output logic          explored,
  output logic          busy
);

  typedef enum logic [2:0] {
    StIdle,
    StExplore,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           lfsr_q;
  logic [3:0]           st_q, st_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           cand_q, cand_d;
  logic signed [QW-1:0] best_q, best_d;
  logic [1:0]           best_idx_q, best_idx_d;
  logic                 fire_q, fire_d;
  logic                 fire_expl_q, fire_expl_d;
  logic [1:0]           act_q;
  logic                 act_valid_q;
  logic                 explored_q;

  // Taps x^8+x^6+x^5+x^4+1; maximal length so a nonzero seed never reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    fire_d      = 1'b0;
    fire_expl_d = fire_expl_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          st_d = st;
          if (lfsr_q < epsilon) begin
            cand_d  = lfsr_q[1:0];
            state_d = StExplore;
          end else begin
            idx_d   = 2'd0;
            state_d = StReq;
          end
        end
      end
      StExplore: begin
        fire_d      = 1'b1;
        fire_expl_d = 1'b1;
        state_d     = StIdle;
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (q_rd_valid) begin
          // Strict compare keeps the lower index on ties.
          if ((idx_q == 2'd0) || ($signed(q_rd_data) > best_q)) begin
            best_d     = $signed(q_rd_data);
            best_idx_d = idx_q;
          end
          if (idx_q == 2'd3) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StReq;
          end
        end
      end
      StDone: begin
        fire_d      = 1'b1;
        fire_expl_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      st_q        <= 4'd0;
      idx_q       <= 2'd0;
      cand_q      <= 2'd0;
      best_q      <= '0;
      best_idx_q  <= 2'd0;
      fire_q      <= 1'b0;
      fire_expl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      fire_q      <= fire_d;
      fire_expl_q <= fire_expl_d;
    end
  end

  // Result stage: act, explored and act_valid all move together one cycle after the decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q       <= 2'd0;
      act_valid_q <= 1'b0;
      explored_q  <= 1'b0;
    end else begin
      act_valid_q <= fire_q;
      if (fire_q) begin
        act_q      <= fire_expl_q ? cand_q : best_idx_q;
        explored_q <= fire_expl_q;
      end
    end
  end

  assign q_rd_en   = (state_q == StReq);
  assign q_state   = st_q;
  assign q_act     = idx_q;
  assign act       = act_q;
  assign act_valid = act_valid_q;
  assign explored  = explored_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_action_selector.sv
// Directed bench for action_selector with a Q-table responder, pulse monitor and LFSR model.
module tb_action_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  st = 4'd0;
  logic [7:0]  epsilon = 8'd0;
  logic        q_rd_en;
  logic [3:0]  q_state;
  logic [1:0]  q_act;
  logic        q_rd_valid = 1'b0;
  logic [15:0] q_rd_data = 16'd0;
  logic [1:0]  act;
  logic        act_valid;
  logic        explored;
  logic        busy;

  action_selector #(
    .QW       (16),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .st        (st),
    .epsilon   (epsilon),
    .q_rd_en   (q_rd_en),
    .q_state   (q_state),
    .q_act     (q_act),
    .q_rd_valid(q_rd_valid),
    .q_rd_data (q_rd_data),
    .act       (act),
    .act_valid (act_valid),
    .explored  (explored),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: x^8+x^6+x^5+x^4+1 from 8'hA5
  logic [7:0] m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= 8'hA5;
    else      m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  // Q-table responder
  logic [15:0] qv [4];
  bit          rnd_dly = 1'b0;
  bit          inject = 1'b0;
  int          fixed_dly = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [1:0]  ract = 2'd0;

  always @(negedge clk) begin
    if (!rst) begin
      pend       <= 1'b0;
      q_rd_valid <= 1'b0;
    end else begin
      q_rd_valid <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          q_rd_valid <= 1'b1;
          q_rd_data  <= qv[ract];
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (q_rd_en) begin
        pend <= 1'b1;
        ract <= q_act;
        cnt  <= rnd_dly ? int'($urandom_range(5, 0)) : fixed_dly;
        if (inject) begin
          q_rd_valid <= 1'b1;
          q_rd_data  <= 16'h7FFF;
        end
      end
    end
  end

  // Pulse monitor
  int         en_cnt = 0;
  int         av_cnt = 0;
  int         av_cyc = 0;
  logic [1:0] seq [64];
  always @(negedge clk) begin
    if (q_rd_en) begin
      seq[en_cnt[5:0]] <= q_act;
      en_cnt           <= en_cnt + 1;
    end
    if (act_valid) begin
      av_cnt <= av_cnt + 1;
      av_cyc <= cyc;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_q(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    qv[0] = a;
    qv[1] = b;
    qv[2] = c;
    qv[3] = d;
  endtask

  task automatic go(input logic [3:0] s, input logic [7:0] e, output int sc);
    st      = s;
    epsilon = e;
    start   = 1'b1;
    sc      = cyc + 1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_av(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (av_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [3:0] s, input logic [7:0] e,
                     input logic [1:0] exp_act, input logic exp_expl, input int exp_en,
                     input int exp_lat, input int budget);
    int sc;
    int en0;
    int av0;
    bit ok;
    en0 = en_cnt;
    av0 = av_cnt;
    go(s, e, sc);
    wait_av(av0, budget, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_act"}, 32'(act), 32'(exp_act));
    check({tag, "_explored"}, 32'(explored), 32'(exp_expl));
    check({tag, "_rd_en_count"}, 32'(en_cnt - en0), 32'(exp_en));
    check({tag, "_q_state"}, 32'(q_state), 32'(s));
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(av_cyc - sc), 32'(exp_lat));
    tick();
    check({tag, "_pulse_width"}, 32'(act_valid), 32'd0);
  endtask

  initial begin
    int  sc;
    int  en0;
    int  av0;
    bit  ok;

    // Reset
    repeat (3) tick();
    check("rst_act", 32'(act), 32'd0);
    check("rst_act_valid", 32'(act_valid), 32'd0);
    check("rst_explored", 32'(explored), 32'd0);
    check("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    check("rst_q_act", 32'(q_act), 32'd0);
    check("rst_q_state", 32'(q_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // First edge out of reset sees lfsr=8'hA5 -> explore, act=2'b01
    run("seed", 4'd3, 8'd255, 2'd1, 1'b1, 0, 2, 20);

    // Exploit, distinct values
    set_q(16'sd10, -16'sd3, 16'sd42, 16'sd7);
    en0 = en_cnt;
    run("exploit", 4'd5, 8'd0, 2'd2, 1'b0, 4, 10, 40);
    for (int i = 0; i < 4; i++) check("exploit_q_act_seq", 32'(seq[(en0 + i) % 64]), 32'(i));

    // Ties and negatives
    set_q(-16'sd8, -16'sd8, -16'sd20, -16'sd8);
    run("tie_neg", 4'd1, 8'd0, 2'd0, 1'b0, 4, 10, 40);
    set_q(-16'sd1, 16'sd5, 16'sd5, 16'h8000);
    run("tie_mid", 4'd2, 8'd0, 2'd1, 1'b0, 4, 10, 40);

    // Explore from a running LFSR
    if (m == 8'hFF) tick();
    run("explore", 4'd4, 8'd255, m[1:0], 1'b1, 0, 2, 20);

    // epsilon boundary: lfsr == epsilon exploits, lfsr == epsilon-1 explores
    set_q(16'sd3, 16'sd1, 16'sd4, 16'sd1);
    run("eps_eq", 4'd6, m, 2'd2, 1'b0, 4, 10, 40);
    if (m == 8'hFF) tick();
    run("eps_above", 4'd8, m + 8'd1, m[1:0], 1'b1, 0, 2, 20);

    // Stalled handshake, spurious valid in REQ, start while busy
    set_q(16'sd100, -16'sd50, 16'sd300, 16'sd200);
    rnd_dly = 1'b1;
    inject  = 1'b1;
    en0 = en_cnt;
    av0 = av_cnt;
    go(4'd7, 8'd0, sc);
    check("stall_busy", 32'(busy), 32'd1);
    tick();
    tick();
    st      = 4'd9;
    epsilon = 8'd255;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    epsilon = 8'd0;
    wait_av(av0, 80, ok);
    check("stall_done", 32'(ok), 32'd1);
    check("stall_act", 32'(act), 32'd2);
    check("stall_explored", 32'(explored), 32'd0);
    check("stall_q_state", 32'(q_state), 32'd7);
    repeat (15) tick();
    check("stall_av_count", 32'(av_cnt - av0), 32'd1);
    check("stall_rd_en_count", 32'(en_cnt - en0), 32'd4);
    rnd_dly = 1'b0;
    inject  = 1'b0;

    // Reset while waiting on the third read
    fixed_dly = 2;
    set_q(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    en0 = en_cnt;
    av0 = av_cnt;
    go(4'd2, 8'd0, sc);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (en_cnt - en0 >= 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("abort_reach_third_read", 32'(ok), 32'd1);
    tick();
    check("abort_busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_act", 32'(act), 32'd0);
    check("abort_q_state", 32'(q_state), 32'd0);
    check("abort_q_rd_en", 32'(q_rd_en), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("abort_no_act_valid", 32'(av_cnt - av0), 32'd0);
    fixed_dly = 0;
    run("after_abort", 4'd2, 8'd0, 2'd3, 1'b0, 4, 10, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/action_selector.md
Name: action_selector

Overview:
- Epsilon-greedy action selection stage, directly upstream of the grid environment checker; produces the 2-bit action (0=right, 1=up, 2=left, 3=down) the checker consumes.
- On a start pulse it latches the current state (1..9) and decides between two paths. The explore path takes a pseudo-random action from an LFSR. The exploit path reads the four Q-values for the state from the Q-table over a valid handshake and picks the argmax.
- Result is presented with a one-cycle act_valid pulse and held on act until the next decision.

Parameters:
- QW, 16, width of signed Q-values.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request for a new action; ignored while busy=1.
- st  in  4  current state (1..9), sampled when start is accepted.
- epsilon  in  8  exploration threshold; explore iff lfsr < epsilon.
- q_rd_en  out  1  one-cycle Q-table read strobe.
- q_state  out  4  state for the Q read (latched st).
- q_act  out  2  action index for the Q read.
- q_rd_valid  in  1  Q-table read data valid; honoured only in WAIT.
- q_rd_data  in  QW  signed Q-value.
- act  out  2  selected action, held until the next act_valid.
- act_valid  out  1  one-cycle pulse, act is new.
- explored  out  1  1 = last act came from the explore path; updates with act_valid.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=0, async) sets:
  - state IDLE, lfsr=LFSR_SEED;
  - act=0, act_valid=0, explored=0, q_rd_en=0, q_act=0, q_state=0, busy=0;
  - internal best value and best index cleared.
- A reset asserted mid-operation aborts the decision; no act_valid is emitted.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It shifts every clock out of reset regardless of FSM state, and never takes the value 0.
- IDLE, start=1:
  - latch st into q_state; compare the current lfsr value against epsilon.
  - if lfsr < epsilon: go to EXPLORE and capture lfsr[1:0] as the candidate action.
  - else: go to REQ with index i=0.
- EXPLORE (1 cycle): act <= captured bits, explored <= 1, act_valid pulses on the next cycle, return to IDLE. Explore latency is start edge to act_valid high = 2 cycles.
- REQ (1 cycle): q_rd_en=1, q_act=i, then go to WAIT.
- WAIT: hold q_act=i; stay here until q_rd_valid=1. On q_rd_valid, compare q_rd_data against best:
  - the new value is taken when i==0 or when q_rd_data > best (signed, strict);
  - ties keep the lower index.
  - if i<3: i++ and go to REQ; else go to DONE.
- DONE (1 cycle): act <= best index, explored <= 0, act_valid pulses, return to IDLE.
- Exploit minimum latency, with q_rd_valid one cycle after q_rd_en: start edge to act_valid high = 10 cycles.
- q_rd_valid outside WAIT is ignored. start while busy is ignored (not queued).
- epsilon=0: never explore. epsilon=255: always explore except when lfsr==255.
- Q-values are compared as full QW-bit two's complement; no saturation or arithmetic on them.
- act and explored change only on the cycle act_valid rises.

Test Plan:
1. Reset: rst=0 for 3 cycles, then 1 -> all outputs 0, busy=0; lfsr sequence starts from 8'hA5.
2. Exploit, distinct values: epsilon=0, st=5, start; Q responses {10,-3,42,7}, each returned 1 cycle after q_rd_en -> q_state=5, q_act visits 0,1,2,3; act=2, explored=0; act_valid exactly 10 cycles after start.
3. Ties and negative values: epsilon=0; Q={-8,-8,-20,-8} -> act=0. Q={-1,5,5,-32768} -> act=1.
4. Explore: epsilon=255 with lfsr!=255 at start -> no q_rd_en; act = lfsr[1:0] at start; explored=1; act_valid 2 cycles after start.
5. Handshake stall: epsilon=0; delay q_rd_valid by 0 to 5 random cycles per read; inject a spurious q_rd_valid during REQ and a start while busy -> both ignored, exactly 4 q_rd_en pulses, single act_valid, correct argmax.
6. Reset mid-fetch: assert rst in WAIT after 2 reads -> immediate IDLE, no act_valid. A subsequent start with epsilon=0 and Q={1,2,3,4} -> act=3.
